// File: rtl/snd_tone_gen.sv
// snd_tone_gen: square-wave beep sample generator feeding the spi_dac over valid/ready.
// Optional SND_FADE_EN adds a linear attack/release envelope on the amplitude.
module snd_tone_gen #(
    parameter int CLK_DIV = 2500,
    parameter int PER_W   = 12,
    parameter int DUR_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [DUR_W-1:0] cmd_duration,
    input  logic [6:0]       cmd_amp,
    input  logic             stop,
    output logic [7:0]       sound_data,
    output logic             sound_valid,
    input  logic             snddac_ready,
    output logic             busy,
    output logic             overrun
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, PLAY, SILENCE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic [PER_W-1:0] period_q, hp_cnt;
    logic [DUR_W-1:0] dur_q;
    logic [6:0]       amp_q;
    logic             phase;
    logic             accept, issue, go_sil;
    logic [7:0]       issue_data, offset;

    assign tick      = cnt == CW'(CLK_DIV - 1);
    assign cmd_ready = state == IDLE;
    assign busy      = state == PLAY;
    assign accept    = cmd_valid & cmd_ready;

`ifdef SND_FADE_EN
    logic [7:0]  env;
    logic        fading;
    logic [14:0] prod;
    assign prod   = amp_q * env;
    assign offset = {1'b0, prod[14:8]};
    assign go_sil = fading && env == 8'd0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env    <= 8'd0;
            fading <= 1'b0;
        end else if (accept) begin
            env    <= 8'd0;
            fading <= 1'b0;
        end else if (state == PLAY) begin
            if (stop)
                fading <= 1'b1;
            if (tick)
                env <= (fading || dur_q < DUR_W'(32)) ? (env < 8'd8 ? 8'd0 : env - 8'd8)
                                                      : (env > 8'd247 ? 8'd255 : env + 8'd8);
        end
    end
`else
    assign offset = {1'b0, amp_q};
    assign go_sil = stop;
`endif

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        issue_data = 8'h80;
        case (state)
            IDLE:    state_nx = cmd_valid ? PLAY : IDLE;
            PLAY: begin
                if (go_sil)
                    state_nx = SILENCE;
                else if (tick) begin
                    issue      = dur_q != '0;
                    issue_data = phase ? 8'h80 + offset : 8'h80 - offset;
                    state_nx   = dur_q <= DUR_W'(1) ? SILENCE : PLAY;
                end
            end
            SILENCE: begin
                issue    = tick;
                state_nx = tick ? IDLE : SILENCE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            period_q    <= '0;
            hp_cnt      <= '0;
            dur_q       <= '0;
            amp_q       <= '0;
            phase       <= 1'b1;
            sound_data  <= 8'h80;
            sound_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= tick ? '0 : cnt + CW'(1);
            if (accept) begin
                period_q <= cmd_period == '0 ? PER_W'(1) : cmd_period;
                dur_q    <= cmd_duration;
                amp_q    <= cmd_amp;
                phase    <= 1'b1;
                hp_cnt   <= '0;
            end else if (issue && state == PLAY) begin
                dur_q  <= dur_q - DUR_W'(1);
                hp_cnt <= hp_cnt == period_q - PER_W'(1) ? '0 : hp_cnt + PER_W'(1);
                if (hp_cnt == period_q - PER_W'(1))
                    phase <= ~phase;
            end
            // an issue coinciding with an accept refreshes valid without flagging overrun
            sound_valid <= issue | (sound_valid & ~snddac_ready);
            if (issue)
                sound_data <= issue_data;
            overrun <= accept ? 1'b0 : overrun | (issue & sound_valid & ~snddac_ready);
        end
    end
endmodule

// File: tb/tb_snd_tone_gen.sv
// tb_snd_tone_gen: directed tests for snd_tone_gen with CLK_DIV=4.
module tb_snd_tone_gen;
    localparam int CLK_DIV = 4;
    localparam int PER_W   = 12;
    localparam int DUR_W   = 16;

    logic             clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, stop = 1'b0, snddac_ready = 1'b1;
    logic             cmd_ready, sound_valid, busy, overrun;
    logic [PER_W-1:0] cmd_period = '0;
    logic [DUR_W-1:0] cmd_duration = '0;
    logic [6:0]       cmd_amp = '0;
    logic [7:0]       sound_data;
    int               errors = 0, checks = 0, cyc = 0;
    logic [7:0]       q[$];
    int               tq[$];

    snd_tone_gen #(.CLK_DIV(CLK_DIV), .PER_W(PER_W), .DUR_W(DUR_W)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_period(cmd_period), .cmd_duration(cmd_duration), .cmd_amp(cmd_amp), .stop(stop),
        .sound_data(sound_data), .sound_valid(sound_valid), .snddac_ready(snddac_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // samples handed to the DAC, recorded once per accepting cycle
    always @(negedge clk)
        if (reset_n && sound_valid && snddac_ready) begin
            q.push_back(sound_data);
            tq.push_back(cyc);
        end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PER_W-1:0] p, input logic [DUR_W-1:0] d, input logic [6:0] a);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_period = p; cmd_duration = d; cmd_amp = a;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (!cmd_ready && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: cmd_ready still %b after %0d cycles, expected 1", name, cmd_ready, max);
        end
    endtask

    task automatic check_q(input string name, input logic [7:0] e[$]);
        checks++;
        if (q.size() !== e.size()) begin
            errors++;
            $display("FAIL %s: sample count %0d, expected %0d", name, q.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < q.size(); i++) begin
            checks++;
            if (q[i] !== e[i]) begin
                errors++;
                $display("FAIL %s[%0d]: sample %h, expected %h", name, i, q[i], e[i]);
            end
        end
    endtask

    task automatic test_reset;
        cycles(3);
        checks++;
        if ({sound_data, sound_valid, cmd_ready, busy, overrun} !== {8'h80, 4'b0100}) begin
            errors++;
            $display("FAIL reset: data=%h valid=%b ready=%b busy=%b ovr=%b, expected 80 0 1 0 0",
                     sound_data, sound_valid, cmd_ready, busy, overrun);
        end
        reset_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_tone;
        logic [7:0] e[$];
        q.delete(); tq.delete();
        send(12'd2, 16'd6, 7'h20);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL tone_busy: busy=%b ready=%b, expected 1 0", busy, cmd_ready);
        end
        wait_idle("tone_idle", 40);
        cycles(2);
        e = '{8'hA0, 8'hA0, 8'h60, 8'h60, 8'hA0, 8'hA0, 8'h80};
        check_q("tone", e);
        checks++;
        if (tq.size() == 7 && (tq[1] - tq[0] !== CLK_DIV || tq[6] - tq[5] !== CLK_DIV)) begin
            errors++;
            $display("FAIL tone_spacing: %0d/%0d cycles, expected %0d", tq[1] - tq[0], tq[6] - tq[5], CLK_DIV);
        end
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tone_end: overrun=%b busy=%b, expected 0 0", overrun, busy);
        end
    endtask

    task automatic test_period_zero;
        logic [7:0] e[$];
        q.delete();
        send(12'd0, 16'd3, 7'h7F);
        wait_idle("p0_idle", 30);
        cycles(2);
        e = '{8'hFF, 8'h01, 8'hFF, 8'h80};
        check_q("period0", e);
    endtask

    task automatic test_dur_zero;
        logic [7:0] e[$];
        q.delete();
        send(12'd5, 16'd0, 7'h10);
        wait_idle("d0_idle", 12);
        cycles(2);
        e = '{8'h80};
        check_q("dur0", e);
    endtask

    task automatic test_overrun_stop;
        logic [7:0] e[$];
        int n = 0;
        q.delete();
        send(12'd100, 16'd20, 7'h20);
        while (q.size() == 0 && n < 12) begin
            cycles(1);
            n++;
        end
        checks++;
        if (q.size() == 0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: samples=%0d overrun=%b, expected >=1 and 0", q.size(), overrun);
        end
        snddac_ready = 1'b0;
        cycles(12);
        checks++;
        if ({sound_valid, sound_data, overrun} !== {1'b1, 8'hA0, 1'b1}) begin
            errors++;
            $display("FAIL overrun: valid=%b data=%h ovr=%b, expected 1 a0 1", sound_valid, sound_data, overrun);
        end
        snddac_ready = 1'b1;
        cycles(2);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: overrun=%b, expected 1", overrun);
        end
        stop = 1'b1;
        cycles(1);
        stop = 1'b0;
        q.delete();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_busy: busy=%b, expected 0", busy);
        end
        wait_idle("stop_idle", 12);
        cycles(2);
        e = '{8'h80};
        check_q("stop", e);
        send(12'd1, 16'd0, 7'h00);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%b, expected 0", overrun);
        end
        wait_idle("clr_idle", 12);
        cycles(2);
    endtask

    task automatic test_async_reset;
        send(12'd3, 16'd50, 7'h30);
        cycles(10);
        snddac_ready = 1'b0;
        cycles(8);
        checks++;
        if (sound_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b busy=%b, expected 1 1", sound_valid, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({sound_valid, sound_data, cmd_ready, busy, overrun} !== {1'b0, 8'h80, 3'b100}) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h ready=%b busy=%b ovr=%b, expected 0 80 1 0 0",
                     sound_valid, sound_data, cmd_ready, busy, overrun);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        snddac_ready = 1'b1;
        q.delete();
        cycles(16);
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset: %0d samples issued, expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_period_zero();
        test_dur_zero();
        test_overrun_stop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
